// File: rtl/core_regfile_pkg.sv
// Shared core defines: datapath types, status-register layout and SPR indices
// used by the register file and the SPR/exception block.
package core_regfile_pkg;

  typedef logic [31:0] data_t;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] reg_t;
  typedef logic [4:0]  reg_addr_t;

  // Packed LSB-last: ie lands on bit 0 and sm on bit 1.
  typedef struct packed {
    logic [29:0] rsvd;
    logic        sm;
    logic        ie;
  } sr_t;

  localparam int SR_IE_BIT = 0;
  localparam int SR_SM_BIT = 1;

  localparam sr_t SR_RESET = 32'h0000_0002;

  localparam logic [4:0] SPR_SR  = 5'd0;
  localparam logic [4:0] SPR_EPC = 5'd1;
  localparam logic [4:0] SPR_ESR = 5'd2;

endpackage

// File: rtl/core_regfile_spr.sv
// Special-purpose registers (SR, ESR, EPC) and exception entry/return sequencing.
// Priority per cycle: exception entry, then exception return, then MOV-to-SPR.
module core_spr
  import core_regfile_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        spr_we,
  input  logic [4:0]  spr_addr,
  input  logic [31:0] spr_wdata,
  input  logic        exc_req,
  input  addr_t       exc_pc,
  input  logic        eret,
  output sr_t         sr,
  output sr_t         esr,
  output reg_t        epc,
  output logic        in_exc
);

  sr_t  sr_q, sr_d;
  sr_t  esr_q, esr_d;
  reg_t epc_q, epc_d;
  logic in_exc_q, in_exc_d;

  always_comb begin
    sr_d     = sr_q;
    esr_d    = esr_q;
    epc_d    = epc_q;
    in_exc_d = in_exc_q;
    if (exc_req) begin
      // Nested entry simply overwrites the saved context; no stack is kept.
      esr_d    = sr_q;
      epc_d    = exc_pc;
      sr_d.ie  = 1'b0;
      sr_d.sm  = 1'b1;
      in_exc_d = 1'b1;
    end else if (eret) begin
      sr_d     = esr_q;
      in_exc_d = 1'b0;
    end else if (spr_we) begin
      case (spr_addr)
        SPR_SR:  sr_d  = sr_t'(spr_wdata);
        SPR_EPC: epc_d = spr_wdata;
        SPR_ESR: esr_d = sr_t'(spr_wdata);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q     <= SR_RESET;
      esr_q    <= '0;
      epc_q    <= '0;
      in_exc_q <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      esr_q    <= esr_d;
      epc_q    <= epc_d;
      in_exc_q <= in_exc_d;
    end
  end

  assign sr     = sr_q;
  assign esr    = esr_q;
  assign epc    = epc_q;
  assign in_exc = in_exc_q;

endmodule

// File: rtl/core_regfile.sv
// 32x32 general-purpose register file with two combinational read ports,
// same-cycle writeback bypass and a hard-wired zero r0; hosts the SPR block.
module core_regfile
  import core_regfile_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  reg_addr_t   rd_a_addr,
  output data_t       rd_a_data,
  input  reg_addr_t   rd_b_addr,
  output data_t       rd_b_data,
  input  logic        wb,
  input  reg_addr_t   wb_addr,
  input  data_t       wb_data,
  input  logic        spr_we,
  input  logic [4:0]  spr_addr,
  input  logic [31:0] spr_wdata,
  input  logic        exc_req,
  input  addr_t       exc_pc,
  input  logic        eret,
  output sr_t         sr,
  output sr_t         esr,
  output reg_t        epc,
  output logic        in_exc
);

  data_t gpr_q [32];
  data_t gpr_d [32];
  logic  wb_en;

  // Gating with rst keeps the bypass from leaking a write that reset discards.
  assign wb_en = wb && rst && (wb_addr != '0);

  always_comb begin
    gpr_d = gpr_q;
    if (wb_en) begin
      gpr_d[wb_addr] = wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        gpr_q[i] <= '0;
      end
    end else begin
      gpr_q <= gpr_d;
    end
  end

  always_comb begin
    rd_a_data = '0;
    if (rd_a_addr != '0) begin
      rd_a_data = (wb_en && wb_addr == rd_a_addr) ? wb_data : gpr_q[rd_a_addr];
    end
  end

  always_comb begin
    rd_b_data = '0;
    if (rd_b_addr != '0) begin
      rd_b_data = (wb_en && wb_addr == rd_b_addr) ? wb_data : gpr_q[rd_b_addr];
    end
  end

  core_spr u_spr (
    .clk       (clk),
    .rst       (rst),
    .spr_we    (spr_we),
    .spr_addr  (spr_addr),
    .spr_wdata (spr_wdata),
    .exc_req   (exc_req),
    .exc_pc    (exc_pc),
    .eret      (eret),
    .sr        (sr),
    .esr       (esr),
    .epc       (epc),
    .in_exc    (in_exc)
  );

endmodule
